// File: rtl/cpu_pkg.sv
// Shared fetch-path types: FIFO entry layout, prefetch FSM states and the default reset PC.
package cpu_pkg;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_prefetch_buffer_if.sv
// Bundles the instruction-memory request/ack bus and the IF-stage delivery signals.
interface fetch_prefetch_buffer_if;

  // Memory side: mem_req holds with a stable mem_addr until a single-cycle mem_ack
  // returns mem_rdata; one request in flight. IF side: an instruction is consumed in
  // any cycle where instr_valid=1 and stall=0.
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        stall;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_ack, mem_rdata, stall
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_ack, mem_rdata, stall
  );

endinterface

// File: rtl/prefetch_fifo.sv
// Circular buffer of fetch entries with synchronous push/pop/flush and an occupancy count.
module prefetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             push_data,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t       mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;

  // DEPTH is a power of two, so the pointers wrap without explicit compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst)
    (pop && !flush) |-> (count != '0));

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer: one outstanding memory fetch feeding a small FIFO for IF.
// Optional PREFETCH_BYPASS_EN forwards ack data straight to IF when the FIFO is empty.
module fetch_prefetch_buffer
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hlt,
  input  logic                    redirect,
  input  logic [15:0]             redirect_pc,
  fetch_prefetch_buffer_if.master bus,
  output fetch_state_t            fsm_state
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  fetch_state_t  state_q;
  fetch_state_t  state_d;
  logic [15:0]   fetch_pc_q;
  logic [15:0]   fetch_pc_d;
  logic [15:0]   req_addr_q;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic          fifo_valid;
  logic          ack_ok;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          issue;

  assign fifo_valid = (count != '0);
  assign ack_ok     = (state_q == WAIT) && bus.mem_ack && !redirect;

`ifdef PREFETCH_BYPASS_EN
  assign bypass = ack_ok && !fifo_valid;
`else
  assign bypass = 1'b0;
`endif

  // Redirect wins over pop and push; a bypassed word consumed by IF never enters the FIFO.
  assign pop       = fifo_valid && !bus.stall && !redirect;
  assign push      = ack_ok && !(bypass && !bus.stall);
  assign push_data = '{pc: fetch_pc_q, instr: bus.mem_rdata};

  // A request reserves a slot, counted after this cycle's pop, so its ack always fits.
  assign issue = !hlt && !redirect && ((count - CW'(pop)) < DEPTH_C);

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      IDLE: begin
        if (redirect)   fetch_pc_d = redirect_pc;
        else if (issue) state_d    = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = bus.mem_ack ? IDLE : DROP;
        end else if (bus.mem_ack) begin
          fetch_pc_d = fetch_pc_q + 16'd1;
          state_d    = IDLE;
        end
      end
      DROP: begin
        if (redirect)    fetch_pc_d = redirect_pc;
        if (bus.mem_ack) state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // req_addr is captured at issue so DROP keeps presenting the abandoned address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (state_q == IDLE && state_d == WAIT) req_addr_q <= fetch_pc_q;
    end
  end

  assign bus.mem_req     = (state_q != IDLE);
  assign bus.mem_addr    = req_addr_q;
  assign bus.instr_valid = fifo_valid || bypass;
  assign fsm_state       = state_q;

  always_comb begin
    bus.instr    = '0;
    bus.instr_pc = '0;
    if (bypass) begin
      bus.instr    = bus.mem_rdata;
      bus.instr_pc = fetch_pc_q;
    end else if (fifo_valid) begin
      bus.instr    = head.instr;
      bus.instr_pc = head.pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    push |-> ((count - CW'(pop)) < DEPTH_C));

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
    (state_q != IDLE && !bus.mem_ack) |=> (bus.mem_req && $stable(bus.mem_addr)));

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer (default build, PREFETCH_BYPASS_EN undefined).
module tb_fetch_prefetch_buffer;
  import cpu_pkg::*;

  logic         clk;
  logic         rst;
  logic         hlt;
  logic         redirect;
  logic [15:0]  redirect_pc;
  fetch_state_t fsm_state;
  int           checks;
  int           failures;

  fetch_prefetch_buffer_if bus();

  fetch_prefetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hlt         (hlt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.mem_req), 32'd1);
  endtask

  task automatic serve(input string tag, input logic [15:0] addr,
                       input logic [15:0] data, input int lat);
    wait_req({tag, "_req"});
    chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(addr));
    for (int i = 1; i < lat; i++) tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = data;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic chk_head(input string tag, input logic [15:0] pc, input logic [15:0] ins);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    chk({tag, "_pc"},    32'(bus.instr_pc),    32'(pc));
    chk({tag, "_instr"}, 32'(bus.instr),       32'(ins));
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    hlt           = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    bus.stall     = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_req",   32'(bus.mem_req),     32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_state", 32'(fsm_state),       32'(IDLE));
    rst = 1'b1;

    // in-order fetch with ack latency 2
    serve("t1_a0", 16'h0000, 16'hA000, 2);
    chk_head("t1_h0", 16'h0000, 16'hA000);
    serve("t1_a1", 16'h0001, 16'hA001, 2);
    chk_head("t1_h1", 16'h0001, 16'hA001);
    serve("t1_a2", 16'h0002, 16'hA002, 2);
    chk_head("t1_h2", 16'h0002, 16'hA002);
    tick();

    // fill under stall
    bus.stall = 1'b1;
    serve("t2_a3", 16'h0003, 16'hB003, 1);
    serve("t2_a4", 16'h0004, 16'hB004, 1);
    serve("t2_a5", 16'h0005, 16'hB005, 1);
    serve("t2_a6", 16'h0006, 16'hB006, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_full_noreq", 32'(bus.mem_req), 32'd0);
    end
    chk_head("t2_h3", 16'h0003, 16'hB003);
    bus.stall = 1'b0;
    tick();
    chk("t2_req5", 32'(bus.mem_req), 32'd1);
    chk("t2_addr5", 32'(bus.mem_addr), 32'h0007);
    chk_head("t2_h4", 16'h0004, 16'hB004);
    serve("t2_a7", 16'h0007, 16'hB007, 1);
    chk_head("t2_h5", 16'h0005, 16'hB005);

    // redirect while waiting; late ack dropped
    wait_req("t3_req");
    chk("t3_addr", 32'(bus.mem_addr), 32'h0008);
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    chk("t3_drop_state", 32'(fsm_state),       32'(DROP));
    chk("t3_drop_addr",  32'(bus.mem_addr),    32'h0008);
    chk("t3_flushed",    32'(bus.instr_valid), 32'd0);
    tick();
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    chk("t3_idle",      32'(fsm_state),       32'(IDLE));
    chk("t3_no_dead",   32'(bus.instr_valid), 32'd0);
    wait_req("t3_req2");
    chk("t3_new_addr",  32'(bus.mem_addr),    32'h0040);
    chk("t3_empty",     32'(bus.instr_valid), 32'd0);

    // redirect coincident with ack
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    redirect      = 1'b1;
    redirect_pc   = 16'h0100;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    redirect      = 1'b0;
    chk("t4_idle",     32'(fsm_state),       32'(IDLE));
    chk("t4_no_beef",  32'(bus.instr_valid), 32'd0);
    tick();
    chk("t4_req",      32'(bus.mem_req),     32'd1);
    chk("t4_addr",     32'(bus.mem_addr),    32'h0100);
    chk("t4_empty",    32'(bus.instr_valid), 32'd0);

    // PC wrap and halt
    serve("t5_a100", 16'h0100, 16'hC100, 1);
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    chk("t5_flushed", 32'(bus.instr_valid), 32'd0);
    serve("t5_affff", 16'hFFFF, 16'hC0FF, 1);
    chk_head("t5_hffff", 16'hFFFF, 16'hC0FF);
    tick();
    chk("t5_wrap_req",  32'(bus.mem_req),  32'd1);
    chk("t5_wrap_addr", 32'(bus.mem_addr), 32'h0000);
    hlt           = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hD000;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    chk_head("t5_h0", 16'h0000, 16'hD000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hlt_noreq", 32'(bus.mem_req), 32'd0);
    end

    // reset mid-WAIT, late ack ignored
    hlt = 1'b0;
    tick();
    chk("t6_req",  32'(bus.mem_req),  32'd1);
    chk("t6_addr", 32'(bus.mem_addr), 32'h0001);
    rst = 1'b0;
    #1;
    chk("t6_rst_req",   32'(bus.mem_req),     32'd0);
    chk("t6_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("t6_rst_instr", 32'(bus.instr),       32'd0);
    chk("t6_rst_pc",    32'(bus.instr_pc),    32'd0);
    chk("t6_rst_state", 32'(fsm_state),       32'(IDLE));
    tick();
    tick();
    rst           = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hEEEE;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    chk("t6_first_req",  32'(bus.mem_req),     32'd1);
    chk("t6_first_addr", 32'(bus.mem_addr),    32'h0000);
    chk("t6_late_ign",   32'(bus.instr_valid), 32'd0);
    tick();
    chk("t6_still_wait", 32'(fsm_state),       32'(WAIT));
    chk("t6_still_empty", 32'(bus.instr_valid), 32'd0);
    serve("t6_a0", 16'h0000, 16'h1234, 1);
    chk_head("t6_h0", 16'h0000, 16'h1234);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
